// File: rtl/vga_pattern_sequencer.sv
// Button/auto stepping of the VGA test-pattern code, applied only at vSync falling edges (update 2 clocks after vSync is first seen low).
// No backpressure: a one-deep, last-press-wins request waits for the next frame boundary.
module vga_pattern_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DWELL_FRAMES    = 120,
    parameter logic [7:0]  PATTERN_MASK    = 8'hFF,
    parameter logic [2:0]  RESET_SEL       = 3'd7
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       vSync,
    input  logic       btnNext,
    input  logic       btnPrev,
    input  logic       autoEnable,
    output logic [2:0] selection,
    output logic       selChanged,
    output logic       pending
);

    localparam int unsigned   CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]   DWELL_LAST = 16'(DWELL_FRAMES - 1);
    localparam logic          MASK_ON    = |PATTERN_MASK;

    typedef enum logic [1:0] {IDLE, PEND_NEXT, PEND_PREV} req_state_t;

    req_state_t    state;
    logic [2:0]    vs_sync;
    logic          frame_start;
    logic [1:0]    auto_sync;
    logic [1:0]    btn_raw;
    logic [1:0]    btn_s1;
    logic [1:0]    btn_s2;
    logic [1:0]    btn_acc;
    logic [1:0]    btn_press;
    logic [CW-1:0] db_cnt [2];
    logic [15:0]   frame_cnt;
    logic          req_next;
    logic          req_prev;

    assign btn_raw     = {btnPrev, btnNext};
    assign frame_start = !vs_sync[1] && vs_sync[2];
    // Simultaneous presses cancel each other; an empty mask disables all stepping.
    assign req_next    = MASK_ON && btn_press[0] && !btn_press[1];
    assign req_prev    = MASK_ON && btn_press[1] && !btn_press[0];

    function automatic logic [2:0] step_next(input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] c;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            c = cur + 3'(i);
            if (!found && PATTERN_MASK[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] step_prev(input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] c;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            c = cur - 3'(i);
            if (!found && PATTERN_MASK[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            vs_sync   <= '0;
            auto_sync <= '0;
        end else begin
            vs_sync   <= {vs_sync[1:0], vSync};
            auto_sync <= {auto_sync[0], autoEnable};
        end
    end

    // Counter runs only while the synced level differs from the accepted one.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_acc   <= '0;
            btn_press <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            btn_press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    btn_acc[i]   <= btn_s2[i];
                    btn_press[i] <= btn_s2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            selection  <= RESET_SEL;
            selChanged <= 1'b0;
            pending    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            selChanged <= 1'b0;
            if (frame_start && state != IDLE) begin
                selection  <= (state == PEND_NEXT) ? step_next(selection) : step_prev(selection);
                selChanged <= 1'b1;
                frame_cnt  <= '0;
            end else if (!auto_sync[1]) begin
                frame_cnt <= '0;
            end else if (frame_start && MASK_ON) begin
                if (frame_cnt == DWELL_LAST) begin
                    selection  <= step_next(selection);
                    selChanged <= 1'b1;
                    frame_cnt  <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end

            // A press coinciding with frame_start survives into the next frame.
            if (req_next) begin
                state   <= PEND_NEXT;
                pending <= 1'b1;
            end else if (req_prev) begin
                state   <= PEND_PREV;
                pending <= 1'b1;
            end else if (frame_start) begin
                state   <= IDLE;
                pending <= 1'b0;
            end
        end
    end

endmodule
